word_loader: RTL

//   Byte-serial loader: assembles a 32-bit word from 8 data switches, one byte per button press,
//   LSB first, then offers the word to a downstream register (PC load port) via valid/ready.

---
 rtl/word_loader_pkg.sv | 16 +
 rtl/word_loader_btn_pulse.sv | 87 ++++++++
 rtl/word_loader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/word_loader_pkg.sv
// word_loader_pkg
//   Shared definitions for the byte-serial word loader: FSM state encoding,
//   byte width and default sizing constants.
//   Optional feature macro: WORD_LOADER_DEBOUNCE_EN (button debounce filter).
package word_loader_pkg;

  localparam int BYTE_W        = 8;
  localparam int NBYTES_DEF    = 4;
  localparam int DB_CYCLES_DEF = 250000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/word_loader_btn_pulse.sv
// btn_pulse
//   Turns a raw, asynchronous push-button into a single-cycle pulse on its
//   rising edge: 2-FF synchronizer, optional debounce filter, edge detect.
//   Raw edge -> pulse latency is 3 cycles without the filter.
//   Macro WORD_LOADER_DEBOUNCE_EN: adds a counter filter; the filtered level
//   only follows the input after DB_CYCLES consecutive differing samples.
// Ports
//   Clk     in  1  system clock
//   Rst     in  1  asynchronous active-low reset
//   btn_raw in  1  raw button level
//   pulse   out 1  one-cycle pulse per accepted rising edge
module btn_pulse
  import word_loader_pkg::*;
`ifdef WORD_LOADER_DEBOUNCE_EN
  #(parameter int DB_CYCLES = DB_CYCLES_DEF)
`endif
(
  input  logic Clk,
  input  logic Rst,
  input  logic btn_raw,
  output logic pulse
);

  logic sync1_q, sync2_q;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;
  logic level;

`ifdef WORD_LOADER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the count, so short bounces never get through.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_comb begin
    prev_d  = level;
    pulse_d = level & ~prev_q;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/word_loader.sv
// word_loader
//   Assembles a word from the 8 data switches one byte per Btn press, LSB
//   first, then offers it downstream with valid/ready. Clr aborts at any time.
//   Macro WORD_LOADER_DEBOUNCE_EN enables the button debounce filters.
// Ports
//   Clk        in  1          system clock
//   Rst        in  1          asynchronous active-low reset
//   SW         in  8          byte to capture
//   Btn        in  1          raw capture button
//   Clr        in  1          raw abort/clear button
//   word_out   out 8*NBYTES   assembled word
//   word_valid out 1          word complete, awaiting consumer
//   word_ready in  1          consumer accepts word this cycle
//   byte_idx   out 2          index of the next byte to capture
//   LED        out 8          echo of the last captured byte
module word_loader
  import word_loader_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
`ifdef WORD_LOADER_DEBOUNCE_EN
  , parameter int DB_CYCLES = DB_CYCLES_DEF
`endif
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [BYTE_W-1:0]        SW,
  input  logic                     Btn,
  input  logic                     Clr,
  output logic [BYTE_W*NBYTES-1:0] word_out,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [1:0]               byte_idx,
  output logic [BYTE_W-1:0]        LED
);

  localparam int         WORD_W   = BYTE_W * NBYTES;
  localparam logic [1:0] LAST_IDX = 2'(NBYTES - 1);

  logic btn_p, clr_p;

  btn_pulse
`ifdef WORD_LOADER_DEBOUNCE_EN
    #(.DB_CYCLES(DB_CYCLES))
`endif
  u_btn (
    .Clk     (Clk),
    .Rst     (Rst),
    .btn_raw (Btn),
    .pulse   (btn_p)
  );

  btn_pulse
`ifdef WORD_LOADER_DEBOUNCE_EN
    #(.DB_CYCLES(DB_CYCLES))
`endif
  u_clr (
    .Clk     (Clk),
    .Rst     (Rst),
    .btn_raw (Clr),
    .pulse   (clr_p)
  );

  state_t              state_q, state_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   led_q, led_d;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    led_d      = led_q;

    unique case (state_q)
      ST_COLLECT: begin
        if (btn_p) begin
          word_d[byte_idx_q*BYTE_W +: BYTE_W] = SW;
          led_d = SW;
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = 2'd0;
            state_d    = ST_HOLD;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      ST_HOLD: begin
        // Presses are ignored here so the offered word cannot change.
        if (word_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    // Clear overrides everything, including a same-cycle capture. A
    // same-cycle handshake has already delivered the word, so zeroing the
    // register afterwards is harmless. LED keeps its echo.
    if (clr_p) begin
      state_d    = ST_COLLECT;
      byte_idx_d = 2'd0;
      word_d     = '0;
      led_d      = led_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= ST_COLLECT;
      byte_idx_q <= 2'd0;
      word_q     <= '0;
      led_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      led_q      <= led_d;
    end
  end

  assign word_valid = (state_q == ST_HOLD);
  assign word_out   = word_q;
  assign byte_idx   = byte_idx_q;
  assign LED        = led_q;

endmodule
